// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet constants and the transmit scheduler state type.
package eth_pkg;
  localparam logic [15:0] ETH_IP = 16'h0800;
  localparam logic [15:0] ETH_ARP = 16'h0806;
  localparam logic [7:0] PROTO_UDP = 8'h11;
  localparam logic [7:0] PROTO_ICMP = 8'h01;
  localparam logic [7:0] PROTO_TCP = 8'h06;
  localparam int UDP_HDR_BYTES = 8;
  localparam int IP_UDP_HDR_BYTES = 28;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_RELEASE, S_GAP} tx_state_e;
endpackage

// File: rtl/eth_tx_sched_if.sv
// eth_tx_sched_if: requester, mac_tx and status signals of the tx scheduler.
//   master: scheduler side (drives acks, fs_mac, mode/length fields, status)
//   slave:  requesters + mac_tx side
interface eth_tx_sched_if;
  logic arp_req, arp_ack, udp_req, udp_ack, fs_mac, fd_mac, busy, err_timeout;
  logic [15:0] udp_dlen, mac_mode, udp_tx_dlen, ip_tx_dlen, frame_cnt;
  logic [7:0] ip_mode;
  modport master(
    input arp_req, udp_req, udp_dlen, fd_mac,
    output arp_ack, udp_ack, fs_mac, mac_mode, ip_mode, udp_tx_dlen, ip_tx_dlen, busy, err_timeout, frame_cnt
  );
  modport slave(
    output arp_req, udp_req, udp_dlen, fd_mac,
    input arp_ack, udp_ack, fs_mac, mac_mode, ip_mode, udp_tx_dlen, ip_tx_dlen, busy, err_timeout, frame_cnt
  );
endinterface

// File: rtl/eth_tx_sched_arb.sv
// tx_rr_arb: 2-way ARP/UDP arbiter, ARP preferred unless it won last time.
//   i_arp_req/i_udp_req: pending requests; i_take: grant is being consumed
//   o_gnt_arp/o_gnt_udp: combinational one-hot (or zero) grant
module tx_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic i_arp_req,
  input  logic i_udp_req,
  input  logic i_take,
  output logic o_gnt_arp,
  output logic o_gnt_udp
);
  logic r_last_arp;
  logic w_pick_udp;
  assign w_pick_udp = i_udp_req & (~i_arp_req | r_last_arp);
  assign o_gnt_udp = w_pick_udp;
  assign o_gnt_arp = i_arp_req & ~w_pick_udp;
  // Reset as "last was UDP" so the first contested grant goes to ARP.
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_last_arp <= 1'b0;
    else if (i_take) r_last_arp <= o_gnt_arp;
endmodule

// File: rtl/eth_tx_sched.sv
// eth_tx_sched: shares mac_tx between ARP and UDP sources with IFG and timeout.
//   clk, rst (async active-low); bus: requester handshakes, fs/fd with mac_tx,
//   latched mode/length fields, busy, err_timeout pulse, frame_cnt.
module eth_tx_sched
  import eth_pkg::*;
#(
  parameter int IFG_CYCLES = 12,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int UDP_HDR = UDP_HDR_BYTES,
  parameter int IP_UDP_HDR = IP_UDP_HDR_BYTES
) (
  input logic clk,
  input logic rst,
  eth_tx_sched_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = $clog2(IFG_CYCLES) + 1;
  tx_state_e r_state;
  logic [TW-1:0] r_tcnt;
  logic [GW-1:0] r_gcnt;
  logic r_arp_ack, r_udp_ack, r_fs, r_busy, r_err;
  logic [15:0] r_mac_mode, r_udp_tx_dlen, r_ip_tx_dlen, r_frame_cnt;
  logic [7:0] r_ip_mode;
  logic w_gnt_arp, w_gnt_udp, w_take;
  assign w_take = (r_state == S_IDLE) & (w_gnt_arp | w_gnt_udp);
  tx_rr_arb u_arb (
    .clk(clk),
    .rst(rst),
    .i_arp_req(bus.arp_req),
    .i_udp_req(bus.udp_req),
    .i_take(w_take),
    .o_gnt_arp(w_gnt_arp),
    .o_gnt_udp(w_gnt_udp)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= S_IDLE;
      r_tcnt <= '0;
      r_gcnt <= '0;
      r_arp_ack <= 1'b0;
      r_udp_ack <= 1'b0;
      r_fs <= 1'b0;
      r_busy <= 1'b0;
      r_err <= 1'b0;
      r_frame_cnt <= '0;
      r_mac_mode <= ETH_IP;
      r_ip_mode <= PROTO_UDP;
      r_udp_tx_dlen <= 16'(UDP_HDR);
      r_ip_tx_dlen <= 16'(IP_UDP_HDR);
    end else begin
      r_arp_ack <= 1'b0;
      r_udp_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE:
          if (w_take) begin
            r_state <= S_SEND;
            r_fs <= 1'b1;
            r_busy <= 1'b1;
            r_tcnt <= '0;
            r_arp_ack <= w_gnt_arp;
            r_udp_ack <= w_gnt_udp;
            r_mac_mode <= w_gnt_arp ? ETH_ARP : ETH_IP;
            // ARP frames leave the IP/UDP fields at their previous values.
            if (w_gnt_udp) begin
              r_ip_mode <= PROTO_UDP;
              r_udp_tx_dlen <= bus.udp_dlen + 16'(UDP_HDR);
              r_ip_tx_dlen <= bus.udp_dlen + 16'(IP_UDP_HDR);
            end
          end
        // fd_mac is tested first so a done on the timeout cycle still counts.
        S_SEND:
          if (bus.fd_mac) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_fs <= 1'b0;
            r_state <= S_RELEASE;
          end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_err <= 1'b1;
            r_fs <= 1'b0;
            r_state <= S_RELEASE;
          end else r_tcnt <= r_tcnt + 1'b1;
        S_RELEASE:
          if (!bus.fd_mac) begin
            r_gcnt <= GW'(IFG_CYCLES - 1);
            r_state <= S_GAP;
          end
        S_GAP:
          if (r_gcnt == '0) begin
            r_state <= S_IDLE;
            r_busy <= 1'b0;
          end else r_gcnt <= r_gcnt - 1'b1;
        default: r_state <= S_IDLE;
      endcase
    end
  assign bus.arp_ack = r_arp_ack;
  assign bus.udp_ack = r_udp_ack;
  assign bus.fs_mac = r_fs;
  assign bus.busy = r_busy;
  assign bus.err_timeout = r_err;
  assign bus.frame_cnt = r_frame_cnt;
  assign bus.mac_mode = r_mac_mode;
  assign bus.ip_mode = r_ip_mode;
  assign bus.udp_tx_dlen = r_udp_tx_dlen;
  assign bus.ip_tx_dlen = r_ip_tx_dlen;
endmodule

// File: tb/tb_eth_tx_sched.sv
// tb_eth_tx_sched: directed scenario tests for eth_tx_sched.
module tb_eth_tx_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  eth_tx_sched_if bus ();
  eth_tx_sched dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle;
    int k = 0;
    while (bus.busy && k < 60) begin
      step();
      k++;
    end
  endtask
  task automatic test_reset;
    rst = 1'b0;
    bus.arp_req = 1'b0;
    bus.udp_req = 1'b0;
    bus.fd_mac = 1'b0;
    bus.udp_dlen = 16'h0;
    repeat (3) step();
    checks++; if (bus.fs_mac !== 1'b0) begin errors++; $display("FAIL reset_fs got %b want 0", bus.fs_mac); end
    checks++; if (bus.arp_ack !== 1'b0 || bus.udp_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b%b want 00", bus.arp_ack, bus.udp_ack); end
    checks++; if (bus.err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err_timeout); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.frame_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h want 0000", bus.frame_cnt); end
    checks++; if (bus.mac_mode !== 16'h0800) begin errors++; $display("FAIL reset_mac_mode got %h want 0800", bus.mac_mode); end
    checks++; if (bus.ip_mode !== 8'h11) begin errors++; $display("FAIL reset_ip_mode got %h want 11", bus.ip_mode); end
    checks++; if (bus.udp_tx_dlen !== 16'h0008) begin errors++; $display("FAIL reset_udp_len got %h want 0008", bus.udp_tx_dlen); end
    checks++; if (bus.ip_tx_dlen !== 16'h001C) begin errors++; $display("FAIL reset_ip_len got %h want 001c", bus.ip_tx_dlen); end
    rst = 1'b1;
    step();
  endtask
  task automatic test_udp_only;
    int k;
    bus.udp_dlen = 16'h0010;
    bus.udp_req = 1'b1;
    step();
    checks++; if (bus.udp_ack !== 1'b1 || bus.arp_ack !== 1'b0) begin errors++; $display("FAIL udp_grant got udp=%b arp=%b want 1 0", bus.udp_ack, bus.arp_ack); end
    checks++; if (bus.fs_mac !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL udp_fs got fs=%b busy=%b want 1 1", bus.fs_mac, bus.busy); end
    checks++; if (bus.udp_tx_dlen !== 16'h0018) begin errors++; $display("FAIL udp_len got %h want 0018", bus.udp_tx_dlen); end
    checks++; if (bus.ip_tx_dlen !== 16'h002C) begin errors++; $display("FAIL udp_ip_len got %h want 002c", bus.ip_tx_dlen); end
    checks++; if (bus.mac_mode !== 16'h0800 || bus.ip_mode !== 8'h11) begin errors++; $display("FAIL udp_modes got %h/%h want 0800/11", bus.mac_mode, bus.ip_mode); end
    bus.udp_req = 1'b0;
    step();
    checks++; if (bus.udp_ack !== 1'b0 || bus.fs_mac !== 1'b1) begin errors++; $display("FAIL udp_ack_pulse got ack=%b fs=%b want 0 1", bus.udp_ack, bus.fs_mac); end
    repeat (68) step();
    bus.fd_mac = 1'b1;
    step();
    checks++; if (bus.fs_mac !== 1'b0 || bus.frame_cnt !== 16'd1) begin errors++; $display("FAIL udp_done got fs=%b cnt=%0d want 0 1", bus.fs_mac, bus.frame_cnt); end
    bus.fd_mac = 1'b0;
    k = 0;
    while (bus.busy && k < 40) begin step(); k++; end
    checks++; if (k !== 13) begin errors++; $display("FAIL udp_gap got %0d cycles to idle want 13", k); end
  endtask
  task automatic test_contention;
    int k;
    logic want_arp;
    rst = 1'b0;
    step();
    rst = 1'b1;
    bus.udp_dlen = 16'h0100;
    bus.arp_req = 1'b1;
    bus.udp_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      want_arp = (i % 2) == 0;
      k = 0;
      while (!(bus.arp_ack || bus.udp_ack) && k < 40) begin step(); k++; end
      if (i > 0) begin
        checks++; if (k !== 14) begin errors++; $display("FAIL cont_spacing%0d got %0d want 14", i, k); end
      end
      checks++; if (bus.arp_ack !== want_arp || bus.udp_ack !== !want_arp) begin errors++; $display("FAIL cont_order%0d got arp=%b udp=%b want arp=%b", i, bus.arp_ack, bus.udp_ack, want_arp); end
      checks++; if (bus.mac_mode !== (want_arp ? 16'h0806 : 16'h0800)) begin errors++; $display("FAIL cont_mode%0d got %h want %h", i, bus.mac_mode, want_arp ? 16'h0806 : 16'h0800); end
      checks++; if (bus.ip_tx_dlen !== (i == 0 ? 16'h001C : 16'h011C)) begin errors++; $display("FAIL cont_iplen%0d got %h want %h", i, bus.ip_tx_dlen, i == 0 ? 16'h001C : 16'h011C); end
      if (want_arp) bus.arp_req = 1'b0; else bus.udp_req = 1'b0;
      step();
      bus.arp_req = 1'b1;
      bus.udp_req = 1'b1;
      step();
      bus.fd_mac = 1'b1;
      step();
      checks++; if (bus.fs_mac !== 1'b0) begin errors++; $display("FAIL cont_fall%0d got %b want 0", i, bus.fs_mac); end
      bus.fd_mac = 1'b0;
    end
    bus.arp_req = 1'b0;
    bus.udp_req = 1'b0;
    wait_idle();
    checks++; if (bus.frame_cnt !== 16'd4 || bus.busy !== 1'b0) begin errors++; $display("FAIL cont_cnt got cnt=%0d busy=%b want 4 0", bus.frame_cnt, bus.busy); end
  endtask
  task automatic test_timeout;
    int k;
    bus.udp_dlen = 16'hFFF0;
    bus.udp_req = 1'b1;
    k = 0;
    while (!bus.udp_ack && k < 40) begin step(); k++; end
    checks++; if (bus.udp_ack !== 1'b1) begin errors++; $display("FAIL to_grant got %b want 1", bus.udp_ack); end
    checks++; if (bus.udp_tx_dlen !== 16'hFFF8 || bus.ip_tx_dlen !== 16'h000C) begin errors++; $display("FAIL to_wrap_len got %h/%h want fff8/000c", bus.udp_tx_dlen, bus.ip_tx_dlen); end
    bus.udp_req = 1'b0;
    k = 0;
    while (!bus.err_timeout && k < 5000) begin step(); k++; end
    checks++; if (k !== 4096) begin errors++; $display("FAIL to_latency got %0d want 4096", k); end
    checks++; if (bus.err_timeout !== 1'b1 || bus.fs_mac !== 1'b0) begin errors++; $display("FAIL to_abort got err=%b fs=%b want 1 0", bus.err_timeout, bus.fs_mac); end
    checks++; if (bus.frame_cnt !== 16'd4 || bus.busy !== 1'b1) begin errors++; $display("FAIL to_cnt got cnt=%0d busy=%b want 4 1", bus.frame_cnt, bus.busy); end
    bus.arp_req = 1'b1;
    step();
    checks++; if (bus.err_timeout !== 1'b0) begin errors++; $display("FAIL to_pulse got %b want 0", bus.err_timeout); end
    k = 1;
    while (!bus.arp_ack && k < 40) begin step(); k++; end
    checks++; if (k !== 14 || bus.arp_ack !== 1'b1) begin errors++; $display("FAIL to_next got k=%0d ack=%b want 14 1", k, bus.arp_ack); end
    bus.arp_req = 1'b0;
    step();
    bus.fd_mac = 1'b1;
    step();
    bus.fd_mac = 1'b0;
    wait_idle();
    checks++; if (bus.frame_cnt !== 16'd5) begin errors++; $display("FAIL to_after_cnt got %0d want 5", bus.frame_cnt); end
  endtask
  task automatic test_sticky_fd;
    int k;
    bus.udp_dlen = 16'h0020;
    bus.udp_req = 1'b1;
    k = 0;
    while (!bus.udp_ack && k < 40) begin step(); k++; end
    bus.udp_req = 1'b0;
    bus.arp_req = 1'b1;
    step();
    bus.fd_mac = 1'b1;
    step();
    checks++; if (bus.fs_mac !== 1'b0 || bus.frame_cnt !== 16'd6) begin errors++; $display("FAIL sticky_fall got fs=%b cnt=%0d want 0 6", bus.fs_mac, bus.frame_cnt); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.fs_mac !== 1'b0 || bus.arp_ack !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL sticky_hold%0d got fs=%b ack=%b busy=%b want 0 0 1", i, bus.fs_mac, bus.arp_ack, bus.busy); end
    end
    bus.fd_mac = 1'b0;
    k = 0;
    while (!bus.arp_ack && k < 40) begin step(); k++; end
    checks++; if (k !== 14 || bus.fs_mac !== 1'b1) begin errors++; $display("FAIL sticky_restart got k=%0d fs=%b want 14 1", k, bus.fs_mac); end
    bus.arp_req = 1'b0;
    step();
    bus.fd_mac = 1'b1;
    step();
    bus.fd_mac = 1'b0;
    wait_idle();
    checks++; if (bus.frame_cnt !== 16'd7) begin errors++; $display("FAIL sticky_cnt got %0d want 7", bus.frame_cnt); end
  endtask
  task automatic test_coincidence;
    int k;
    bus.udp_req = 1'b1;
    k = 0;
    while (!bus.udp_ack && k < 40) begin step(); k++; end
    bus.udp_req = 1'b0;
    repeat (4095) step();
    checks++; if (bus.fs_mac !== 1'b1) begin errors++; $display("FAIL coin_pre got fs=%b want 1", bus.fs_mac); end
    bus.fd_mac = 1'b1;
    step();
    checks++; if (bus.err_timeout !== 1'b0 || bus.fs_mac !== 1'b0) begin errors++; $display("FAIL coin_err got err=%b fs=%b want 0 0", bus.err_timeout, bus.fs_mac); end
    checks++; if (bus.frame_cnt !== 16'd8) begin errors++; $display("FAIL coin_cnt got %0d want 8", bus.frame_cnt); end
    bus.fd_mac = 1'b0;
    step();
    checks++; if (bus.err_timeout !== 1'b0) begin errors++; $display("FAIL coin_late_err got %b want 0", bus.err_timeout); end
    wait_idle();
  endtask
  task automatic test_reset_mid_send;
    int k;
    bus.arp_req = 1'b1;
    k = 0;
    while (!bus.arp_ack && k < 40) begin step(); k++; end
    bus.arp_req = 1'b0;
    repeat (3) step();
    checks++; if (bus.fs_mac !== 1'b1 || bus.mac_mode !== 16'h0806) begin errors++; $display("FAIL rst_pre got fs=%b mode=%h want 1 0806", bus.fs_mac, bus.mac_mode); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.fs_mac !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_async got fs=%b busy=%b want 0 0", bus.fs_mac, bus.busy); end
    checks++; if (bus.frame_cnt !== 16'h0 || bus.mac_mode !== 16'h0800) begin errors++; $display("FAIL rst_regs got cnt=%h mode=%h want 0000 0800", bus.frame_cnt, bus.mac_mode); end
    checks++; if (bus.udp_tx_dlen !== 16'h0008 || bus.ip_tx_dlen !== 16'h001C) begin errors++; $display("FAIL rst_lens got %h/%h want 0008/001c", bus.udp_tx_dlen, bus.ip_tx_dlen); end
    #2;
    rst = 1'b1;
    step();
    bus.arp_req = 1'b1;
    bus.udp_req = 1'b1;
    step();
    checks++; if (bus.arp_ack !== 1'b1 || bus.udp_ack !== 1'b0) begin errors++; $display("FAIL rst_first_grant got arp=%b udp=%b want 1 0", bus.arp_ack, bus.udp_ack); end
    bus.arp_req = 1'b0;
    bus.udp_req = 1'b0;
    step();
    bus.fd_mac = 1'b1;
    step();
    bus.fd_mac = 1'b0;
    wait_idle();
    checks++; if (bus.frame_cnt !== 16'd1) begin errors++; $display("FAIL rst_after_cnt got %0d want 1", bus.frame_cnt); end
  endtask
  initial begin
    test_reset();
    test_udp_only();
    test_contention();
    test_timeout();
    test_sticky_fd();
    test_coincidence();
    test_reset_mid_send();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
